// File: rtl/demux_sched.sv
// -----------------------------------------------------------------------------
// demux_sched
//
// Sequencing controller for a 1-to-N demultiplexer. One word at a time is
// captured from a valid/ready producer, held on a shared output bus, and
// offered to exactly one of N_OUT valid/ready consumers. The destination is
// either addressed (in_sel) or taken from an internal round-robin pointer.
// A held word that is not accepted within TIMEOUT cycles is dropped and
// counted (TIMEOUT = 0 disables dropping).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = addressed by in_sel, 1 = round-robin (sampled at capture)
//   in_valid   producer has a word
//   in_ready   controller can capture a word
//   in_data    input word
//   in_sel     destination index when mode = 0
//   out_valid  one-hot valid, bit i = channel i
//   out_ready  per-channel ready
//   out_data   shared output bus (held word)
//   drop_pulse one-cycle pulse per dropped word
//   drop_cnt   saturating count of dropped words
//   busy       high while a word is held
// -----------------------------------------------------------------------------
module demux_sched #(
    parameter int DATA_W  = 8,
    parameter int N_OUT   = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              drop_pulse,
    output logic [7:0]        drop_cnt,
    output logic              busy
);

    // Wait counter only has to reach TIMEOUT-1.
    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t              state_q;
    logic                init_done_q;
    logic [SEL_W-1:0]    rr_ptr_q;
    logic [SEL_W-1:0]    dest_q;
    logic                held_rr_q;
    logic [DATA_W-1:0]   data_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic                drop_pulse_q;
    logic [7:0]          drop_cnt_q;

    logic [SEL_W-1:0]    rr_ptr_d;
    logic [7:0]          drop_cnt_d;
    logic                sel_ok;
    logic                xfer;
    logic                timeout_hit;

    // Destination decode: only the held destination is ever offered.
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_onehot
        assign out_valid[gi] = (state_q == HOLD) && (dest_q == SEL_W'(gi));
    end

    // out_valid is one-hot on dest, so masking with it ignores the ready
    // bits of every non-selected channel.
    assign xfer     = |(out_valid & out_ready);
    assign sel_ok   = ({1'b0, in_sel} < (SEL_W + 1)'(N_OUT));
    assign rr_ptr_d = (rr_ptr_q == SEL_W'(N_OUT - 1)) ? '0 : rr_ptr_q + 1'b1;
    assign drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;

    if (TIMEOUT == 0) begin : g_no_timeout
        assign timeout_hit = 1'b0;
    end else begin : g_timeout
        assign timeout_hit = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));
    end

    assign in_ready   = (state_q == IDLE) && init_done_q;
    assign busy       = (state_q == HOLD);
    assign out_data   = data_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            init_done_q  <= 1'b0;
            rr_ptr_q     <= '0;
            dest_q       <= '0;
            held_rr_q    <= 1'b0;
            data_q       <= '0;
            wait_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            init_done_q  <= 1'b1;
            drop_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        if (!mode && !sel_ok) begin
                            // Unreachable address: consume and drop at once.
                            drop_pulse_q <= 1'b1;
                            drop_cnt_q   <= drop_cnt_d;
                        end else begin
                            data_q     <= in_data;
                            dest_q     <= mode ? rr_ptr_q : in_sel;
                            held_rr_q  <= mode;
                            wait_cnt_q <= '0;
                            state_q    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        // Transfer wins over a coincident timeout.
                        state_q <= IDLE;
                        if (held_rr_q) rr_ptr_q <= rr_ptr_d;
                    end else if (timeout_hit) begin
                        state_q      <= IDLE;
                        drop_pulse_q <= 1'b1;
                        drop_cnt_q   <= drop_cnt_d;
                        if (held_rr_q) rr_ptr_q <= rr_ptr_d;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/demux_sched.md
Name: demux_sched

Overview:
- Sequencing controller for the 1-to-N demultiplexer datapath: accepts one word at a time on a valid/ready input and steers it to exactly one of N_OUT valid/ready output channels.
- Destination is either addressed (in_sel) or round-robin. A held word that is not accepted within TIMEOUT cycles is dropped and counted.
- Sits between a single producer and N_OUT consumers sharing one data bus.

Parameters:
- DATA_W, 8, data word width.
- N_OUT, 4, number of output channels (2..16).
- SEL_W, 2, width of in_sel and rr_ptr; must equal clog2(N_OUT).
- TIMEOUT, 15, cycles a held word waits before being dropped; 0 disables dropping.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = addressed by in_sel, 1 = round-robin; sampled only at capture.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller can capture a word.
- in_data  in  DATA_W  input word.
- in_sel  in  SEL_W  destination index when mode=0.
- out_valid  out  N_OUT  one-hot valid, bit i = channel i.
- out_ready  in  N_OUT  per-channel ready.
- out_data  out  DATA_W  shared output bus (held word).
- drop_pulse  out  1  one-cycle pulse per dropped word.
- drop_cnt  out  8  saturating count of dropped words.
- busy  out  1  high while a word is held.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, init_done=0, rr_ptr=0.
  - in_ready=0, out_valid=0, out_data=0, drop_pulse=0, drop_cnt=0, busy=0.
  - init_done sets on the first rising edge after release; in_ready = (state==IDLE) && init_done.
- IDLE: in_ready=1, out_valid=0, busy=0. On an edge with in_valid && in_ready:
  - Latch in_data, dest = mode ? rr_ptr : in_sel, and held_rr = mode.
  - Clear wait_cnt and go to HOLD.
- Invalid address: mode=0 with in_sel >= N_OUT at capture.
  - The word is consumed and dropped immediately: drop_pulse=1 next cycle, drop_cnt+1, stay IDLE.
  - rr_ptr is unchanged.
- HOLD: in_ready=0, busy=1, out_valid = one-hot(dest), out_data = held word.
  - out_valid and out_data stay stable until the transfer completes or the word is dropped.
- Transfer: edge with out_ready[dest]=1 in HOLD.
  - Go to IDLE. If held_rr=1, rr_ptr advances (N_OUT-1 wraps to 0).
  - out_ready bits of non-selected channels are ignored.
- Timeout: in HOLD without transfer, wait_cnt increments each edge.
  - When wait_cnt==TIMEOUT-1 and out_ready[dest]=0 on that edge: drop the word, drop_pulse=1 for one cycle, drop_cnt+1, go to IDLE.
  - If held_rr=1, rr_ptr still advances.
  - Transfer has priority over timeout on the same edge.
- drop_cnt saturates at 255 and has no wrap. drop_pulse is registered and high exactly one cycle per drop.
- Latency and throughput:
  - Word captured at edge k: out_valid is high after edge k; earliest transfer is edge k+1.
  - in_ready returns high after the transfer edge, so maximum throughput is 1 word per 2 cycles.
- mode or in_sel changes while in HOLD do not affect the held word.
- Reset mid-HOLD: the held word is discarded with no drop_pulse and no count; all outputs return to their reset values immediately.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> in_ready=0 in the first cycle after release and 1 from the next edge; out_valid=0, drop_cnt=0.
- Addressed transfer: mode=0, in_sel=2, in_data=8'hA5, out_ready=4'b0100 -> out_valid=4'b0100 and out_data=A5 for exactly 1 cycle, then IDLE; rr_ptr stays 0.
- Round-robin sweep: mode=1, 5 words 8'h01..8'h05, all out_ready=1 -> channels 0,1,2,3,0 in order; out_valid is always one-hot.
- Back-pressure and non-selected ready: dest=1, out_ready=4'b1101 for 4 cycles, then 4'b0010 -> out_valid=4'b0010 held and stable for 4 cycles, one transfer, no drop.
- Timeout: TIMEOUT=15, out_ready=0 -> drop_pulse exactly 15 cycles after capture, drop_cnt=1, returns to IDLE. Transfer and timeout on the same edge -> transfer, no drop.
- Invalid address, saturation and reset mid-HOLD:
  - N_OUT=3, mode=0, in_sel=3 -> immediate drop_pulse.
  - 260 forced drops -> drop_cnt=255.
  - rst_n pulsed low during HOLD -> out_valid=0 asynchronously, drop_cnt=0.
